// File: rtl/uart_tx_frame.sv
// Purpose: serialise one parallel word into a UART frame (start, data LSB first, optional parity, stop).
// Latency: start bit appears on TX_OUT in the cycle after the capture edge; frame lasts 1+DATA_WIDTH+PAR_EN+1 cycles.
// Backpressure: requests are accepted only in IDLE; DATA_VALID while BUSY is dropped, never queued.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  // Counter must hold the value DATA_WIDTH (number of data bits already emitted).
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shift_reg;   // remaining data bits, next bit to send at [0]
  logic                   par_en_q;    // parity enable latched at capture
  logic                   parity_bit;  // parity value computed from the latched word
  logic [CNT_W-1:0]       bit_cnt;     // data bits already placed on the line
  logic                   tx_q;
  logic                   busy_q;

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

  // Frame sequencer: every output is a register updated here, so nothing from the inputs reaches the pins combinationally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (DATA_VALID) begin
            // Capture edge: start bit and BUSY go out together.
            shift_reg  <= P_DATA;
            par_en_q   <= PAR_EN;
            parity_bit <= PAR_TYP ? ~(^P_DATA) : (^P_DATA);
            bit_cnt    <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_START;
          end
        end

        ST_START: begin
          tx_q      <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= CNT_ONE;
          state     <= ST_DATA;
        end

        ST_DATA: begin
          if (bit_cnt == LAST_CNT) begin
            // Last data bit has been on the line for a full cycle.
            if (par_en_q) begin
              tx_q  <= parity_bit;
              state <= ST_PARITY;
            end else begin
              tx_q  <= 1'b1;
              state <= ST_STOP;
            end
          end else begin
            tx_q      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_ONE;
          end
        end

        ST_PARITY: begin
          tx_q  <= 1'b1;
          state <= ST_STOP;
        end

        ST_STOP: begin
          // DATA_VALID is deliberately not looked at here so BUSY always drops for at least one cycle.
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serialises one parallel byte into a UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits directly upstream of the pulse generator. Its BUSY level output feeds the pulse generator's level input.
- The resulting pulse advances the TX FIFO read pointer in the system controller path.
- CLK is the TX bit-rate clock: one bit per CLK cycle.

Parameters:
- DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.

Ports:
- CLK  input  1  TX bit clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only at the capture edge.
- DATA_VALID  input  1  request to send P_DATA; honoured only in IDLE.
- PAR_EN  input  1  1 = insert parity bit; sampled at the capture edge.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at the capture edge.
- TX_OUT  output  1  serial line, registered; idles high.
- BUSY  output  1  registered; high for the whole frame, start bit through stop bit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While RST=1: state=IDLE, TX_OUT=1, BUSY=0, data and parity registers cleared, bit counter=0.
  - Takes effect immediately, including mid-frame. The partial frame is abandoned and never resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are driven from registers; no combinational path from inputs to outputs.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - Rising edge with DATA_VALID=1 is the capture edge e0. At e0:
    - latch P_DATA, PAR_EN, PAR_TYP;
    - compute parity from the latched data;
    - TX_OUT<=0, BUSY<=1, go to START.
- START: at the next edge, TX_OUT<=data[0], counter<=1, go to DATA.
- DATA: each edge outputs the next bit, LSB first. After data[DATA_WIDTH-1] has been driven for one cycle:
  - go to PARITY if PAR_EN latched = 1;
  - otherwise go to STOP with TX_OUT<=1.
- PARITY:
  - Bit value is ^data for even parity, ~^data for odd parity. The total count of ones in data+parity is then even or odd respectively.
  - Held one cycle, then go to STOP with TX_OUT<=1.
- STOP:
  - TX_OUT=1 for one cycle.
  - At the next edge: go to IDLE, BUSY<=0, TX_OUT stays 1. DATA_VALID is not examined at this edge.
- Frame length: BUSY high for exactly 1+DATA_WIDTH+PAR_EN+1 cycles, i.e. 10 or 11 for DATA_WIDTH=8.
- Inter-frame gap:
  - BUSY must return low for at least one full cycle between frames. Back-to-back merging of frames is forbidden.
  - The downstream pulse generator relies on distinct BUSY rising edges.
  - With DATA_VALID held high continuously, exactly one IDLE cycle separates frames.
- Input changes while BUSY=1:
  - DATA_VALID is ignored and not queued.
  - P_DATA, PAR_EN and PAR_TYP changes have no effect on the frame in flight.
- BUSY rises at e0 together with the start bit: the first cycle TX_OUT=0 is also the first cycle BUSY=1.
- Illegal or unreachable state encodings recover to IDLE on the next edge, with TX_OUT=1 and BUSY=0.

Test Plan:
- Reset then idle: RST pulse, DATA_VALID=0 for 20 cycles -> TX_OUT=1 and BUSY=0 throughout.
- No parity: P_DATA=0xA5, PAR_EN=0, single-cycle DATA_VALID -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,1; BUSY high exactly 10 cycles; TX_OUT=1 afterwards.
- Parity:
  - 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, BUSY high 11 cycles.
  - 0x01, PAR_TYP=0 -> parity bit 1.
  - 0x01, PAR_TYP=1 -> parity bit 0.
- Inputs ignored while busy: during a 0x3C frame, DATA_VALID=1 with P_DATA=0xFF and PAR_EN toggled -> serialised bits still 0,0,1,1,1,1,0,0; no second frame starts.
- Back-to-back: DATA_VALID held high with 0x55 then 0xAA -> two complete frames; BUSY low for exactly 1 cycle between them; checker counts two BUSY rising edges.
- Reset mid-frame: assert RST during data bit 4 of a 0xF0 frame -> TX_OUT=1 and BUSY=0 immediately (asynchronous). After release, the next DATA_VALID with 0x81 produces a clean frame 0,1,0,0,0,0,0,0,1,1.
